tinker_dmem_responder: RTL and testbench
========================================

TINKER_DMEM_RESPONDER -- requirements
Module: tinker_dmem_responder

Interface
REQ-001 SHALL have parameter MEM_BYTES, default 524288, meaning the byte-addressed storage size.
REQ-002 SHALL have parameter LATENCY, default 2, meaning the cycles from request acceptance to response; legal range is 1..15.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-low reset.
REQ-005 SHALL have port req_valid, input, 1 bit: the initiator presents a request.
REQ-006 SHALL have port req_ready, output, 1 bit: the responder can accept a request.
REQ-007 SHALL have port req_write, input, 1 bit: 1 = store, 0 = load.
REQ-008 SHALL have port req_addr, input, 64 bits: byte address.
REQ-009 SHALL have port req_wdata, input, 64 bits: store data, little-endian.
REQ-010 SHALL have port resp_valid, output, 1 bit: a response is present.
REQ-011 SHALL have port resp_ready, input, 1 bit: the initiator accepts the response.
REQ-012 SHALL have port resp_rdata, output, 64 bits: load data, little-endian; 0 for stores and errors.
REQ-013 SHALL have port resp_err, output, 1 bit: the access was rejected.

Function
REQ-014 SHALL implement the state machine IDLE -> WAIT -> RESP -> IDLE.
REQ-015 SHALL assert req_ready only in IDLE; an accept is req_valid && req_ready at a rising edge.
REQ-016 SHALL, on accept, latch write, addr and wdata, load the wait counter with LATENCY-1, and enter WAIT.
REQ-017 SHALL, in WAIT with counter 0, perform the access, register the rdata and err results, and enter RESP; otherwise it SHALL decrement the counter.
REQ-018 SHALL raise resp_valid exactly LATENCY cycles after the accept edge.
REQ-019 SHALL hold resp_valid, resp_rdata and resp_err stable in RESP until resp_ready is high at an edge, then return to IDLE.
REQ-020 SHALL produce a minimum request-to-request spacing of LATENCY+2 cycles when resp_ready is held high.
REQ-021 SHALL form a load as {mem[a+7], ..., mem[a]} and write a store as byte i = wdata[8i+7:8i].
REQ-022 SHALL treat the access as out-of-range when req_addr > MEM_BYTES-8, computed in 64 bits with no wrap-around.
REQ-023 SHALL, for an out-of-range access, set resp_err=1 and resp_rdata=0, and SHALL NOT modify memory.
REQ-024 SHALL ignore req_valid outside IDLE and SHALL NOT queue such a request.
REQ-025 SHALL ignore changes on req_* after the accept edge, because the latched copy is used.

Reset
REQ-026 SHALL, with reset low at an edge, set state=IDLE, req_ready=1 from the next cycle, resp_valid=0, resp_rdata=0, resp_err=0 and counter=0.
REQ-027 SHALL, on reset mid-operation in WAIT, discard the pending store so that memory is unchanged.
REQ-028 SHALL, on reset mid-operation in RESP, drop the response.
REQ-029 SHALL NOT clear memory contents on reset.

Configuration
REQ-030 SHALL, with TINKER_DMEM_MISALIGN_ERR_EN defined, treat req_addr[2:0] != 0 as an error with the same behaviour as out-of-range.
REQ-031 SHALL, without TINKER_DMEM_MISALIGN_ERR_EN, complete misaligned accesses byte-wise per REQ-021.

Structure
REQ-032 SHALL place in shared package tinker_pkg: the state enum (IDLE, WAIT, RESP), the MEM_BYTES default (524288) and the stack-top constant (524288).
REQ-033 SHALL use exactly one sub-module, tinker_byte_mem: byte array storage with one 8-byte little-endian combinational read port and one synchronous write port.

Verification
REQ-034 SHALL verify this store/load sequence: with LATENCY=2, store addr 0x100, data 0x1122334455667788, then load 0x100 -> resp_valid 2 cycles after each accept, err=0, rdata=0x1122334455667788.
REQ-035 SHALL verify byte order: load 0x100 after the store in REQ-034 -> mem[0x100]=0x88 and mem[0x107]=0x11, confirmed by backdoor reads.
REQ-036 SHALL verify the out-of-range boundary: store addr 0x7FFF9 -> err=1, no write; load 0x7FFF8 -> err=0.
REQ-037 SHALL verify backpressure: hold resp_ready=0 for 5 cycles -> resp_valid and rdata stable and req_ready=0 throughout; a second req_valid is ignored.
REQ-038 SHALL verify reset mid-operation: reset low during WAIT of a store 0xDEAD to 0x200 -> mem[0x200] unchanged; after release, resp_valid=0 and req_ready=1.
REQ-039 SHALL verify misalignment: load 0x103 -> with TINKER_DMEM_MISALIGN_ERR_EN, err=1 and rdata=0; without it, err=0 and rdata = bytes 0x103..0x10A.

Source files
------------

// File: rtl/tinker_pkg.sv
// -----------------------------------------------------------------------------
// tinker_pkg
// Shared definitions for the tinker data-memory responder:
//   state_t            responder FSM state (IDLE, WAIT, RESP)
//   MEM_BYTES_DEFAULT  default byte-addressed storage size
//   STACK_TOP          initial stack pointer value (top of data memory)
//   addr_out_of_range  64-bit range check for an 8-byte access
// -----------------------------------------------------------------------------
package tinker_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int unsigned MEM_BYTES_DEFAULT = 524288;
    localparam logic [63:0] STACK_TOP         = 64'd524288;

    // An 8-byte access at addr fits only if addr <= mem_bytes-8. The compare
    // is done in full 64 bits so huge addresses can never wrap into range.
    function automatic logic addr_out_of_range(input logic [63:0] addr,
                                               input int unsigned mem_bytes);
        return addr > (64'(mem_bytes) - 64'd8);
    endfunction

endpackage

// File: rtl/tinker_dmem_responder_if.sv
// -----------------------------------------------------------------------------
// tinker_dmem_responder_if
// Request/response bus between a load/store initiator and the data memory.
//   req_valid/req_ready   request handshake, req_write/req_addr/req_wdata payload
//   resp_valid/resp_ready response handshake, resp_rdata/resp_err payload
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high; the payload must be valid whenever valid is high. The responder holds
// resp_valid and its payload stable until the transfer takes place.
// Modports: master = initiator side, slave = responder side.
// -----------------------------------------------------------------------------
interface tinker_dmem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [63:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/tinker_byte_mem.sv
// -----------------------------------------------------------------------------
// tinker_byte_mem
// Byte-array storage, MEM_BYTES bytes, no reset (contents survive reset).
// Ports:
//   clk    rising-edge clock for the write port
//   we     write enable: stores 8 bytes of wdata starting at waddr
//   waddr  byte address of the write
//   wdata  little-endian write data (byte i = wdata[8i+7:8i])
//   raddr  byte address of the combinational read
//   rdata  {mem[raddr+7], ..., mem[raddr]}
// Callers must keep addresses within MEM_BYTES-8; out-of-range results are
// not meaningful and must be discarded by the caller.
// -----------------------------------------------------------------------------
module tinker_byte_mem #(
    parameter int unsigned MEM_BYTES = 524288
) (
    input  logic                         clk,
    input  logic                         we,
    input  logic [$clog2(MEM_BYTES)-1:0] waddr,
    input  logic [63:0]                  wdata,
    input  logic [$clog2(MEM_BYTES)-1:0] raddr,
    output logic [63:0]                  rdata
);
    localparam int unsigned AW = $clog2(MEM_BYTES);

    logic [7:0] mem [MEM_BYTES];

    always_comb begin
        rdata = '0;
        for (int i = 0; i < 8; i++) begin
            rdata[8*i +: 8] = mem[AW'(raddr + AW'(i))];
        end
    end

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 8; i++) begin
                mem[AW'(waddr + AW'(i))] <= wdata[8*i +: 8];
            end
        end
    end

endmodule

// File: rtl/tinker_dmem_responder.sv
// -----------------------------------------------------------------------------
// tinker_dmem_responder
// Fixed-latency data-memory responder: accepts one 8-byte load/store in IDLE,
// waits LATENCY cycles, then presents the response until it is taken.
// Parameters:
//   MEM_BYTES  storage size in bytes
//   LATENCY    cycles from accept edge to resp_valid, 1..15
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-low reset (memory contents are kept)
//   bus        slave side of tinker_dmem_responder_if
//   state_dbg  current FSM state
// Build option: TINKER_DMEM_MISALIGN_ERR_EN - when defined, an address with
// req_addr[2:0] != 0 is rejected like an out-of-range access; otherwise
// misaligned accesses complete byte-wise.
// -----------------------------------------------------------------------------
module tinker_dmem_responder
    import tinker_pkg::*;
#(
    parameter int unsigned MEM_BYTES = MEM_BYTES_DEFAULT,
    parameter int unsigned LATENCY   = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    tinker_dmem_responder_if.slave   bus,
    output state_t                   state_dbg
);
    localparam int unsigned AW = $clog2(MEM_BYTES);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        lat_write_q, lat_write_d;
    logic [63:0] lat_addr_q, lat_addr_d;
    logic [63:0] lat_wdata_q, lat_wdata_d;
    logic [63:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic        access_err;
    logic        mem_we;
    logic [63:0] mem_rdata;

    // Error decision is made on the latched address so later changes on
    // req_* cannot affect an accepted access.
    always_comb begin
`ifdef TINKER_DMEM_MISALIGN_ERR_EN
        access_err = addr_out_of_range(lat_addr_q, MEM_BYTES) ||
                     (lat_addr_q[2:0] != 3'd0);
`else
        access_err = addr_out_of_range(lat_addr_q, MEM_BYTES);
`endif
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        lat_write_d = lat_write_q;
        lat_addr_d  = lat_addr_q;
        lat_wdata_d = lat_wdata_q;
        rdata_d     = rdata_q;
        err_d       = err_q;
        mem_we      = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    lat_write_d = bus.req_write;
                    lat_addr_d  = bus.req_addr;
                    lat_wdata_d = bus.req_wdata;
                    cnt_d       = 4'(LATENCY - 1);
                    state_d     = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    // Access happens on the edge that enters RESP, so the
                    // response is registered exactly LATENCY edges after accept.
                    mem_we  = lat_write_q && !access_err;
                    err_d   = access_err;
                    rdata_d = (!access_err && !lat_write_q) ? mem_rdata : 64'd0;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (bus.resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            lat_write_q <= 1'b0;
            lat_addr_q  <= 64'd0;
            lat_wdata_q <= 64'd0;
            rdata_q     <= 64'd0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            lat_write_q <= lat_write_d;
            lat_addr_q  <= lat_addr_d;
            lat_wdata_q <= lat_wdata_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
        end
    end

    // Gating with reset drops a store whose write edge coincides with reset.
    tinker_byte_mem #(
        .MEM_BYTES (MEM_BYTES)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we && reset),
        .waddr (lat_addr_q[AW-1:0]),
        .wdata (lat_wdata_q),
        .raddr (lat_addr_q[AW-1:0]),
        .rdata (mem_rdata)
    );

    assign bus.req_ready  = (state_q == IDLE);
    assign bus.resp_valid = (state_q == RESP);
    assign bus.resp_rdata = rdata_q;
    assign bus.resp_err   = err_q;
    assign state_dbg      = state_q;

endmodule

// File: tb/tb_tinker_dmem_responder.sv
module tb_tinker_dmem_responder;
    import tinker_pkg::*;

    localparam int unsigned MEM_BYTES = 524288;
    localparam int unsigned LATENCY   = 2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    tinker_dmem_responder_if bus();
    state_t state_dbg;

    tinker_dmem_responder #(
        .MEM_BYTES (MEM_BYTES),
        .LATENCY   (LATENCY)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus.slave),
        .state_dbg (state_dbg)
    );

    // ---------------- reference model / scoreboard ----------------
    int checks = 0;
    int passed = 0;
    logic [7:0]  mdl [longint];
    logic [63:0] exp_q[$];

    function automatic logic exp_err(input logic [63:0] a);
        logic e;
        e = (a > 64'(MEM_BYTES) - 64'd8);
`ifdef TINKER_DMEM_MISALIGN_ERR_EN
        if (a[2:0] != 3'd0) e = 1'b1;
`endif
        return e;
    endfunction

    // Bytes never written by the bench are unknown; the mask excludes them.
    function automatic void mdl_load(input logic [63:0] a,
                                     output logic [63:0] d,
                                     output logic [63:0] m);
        d = '0;
        m = '0;
        for (int i = 0; i < 8; i++) begin
            if (mdl.exists(longint'(a) + i)) begin
                d[8*i +: 8] = mdl[longint'(a) + i];
                m[8*i +: 8] = 8'hFF;
            end
        end
    endfunction

    function automatic void mdl_store(input logic [63:0] a, input logic [63:0] d);
        for (int i = 0; i < 8; i++) mdl[longint'(a) + i] = d[8*i +: 8];
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic check_backdoor(input string tag, input logic [63:0] a);
        logic [63:0] d, m, got;
        mdl_load(a, d, m);
        got = '0;
        for (int i = 0; i < 8; i++) got[8*i +: 8] = dut.u_mem.mem[19'(a) + 19'(i)];
        check(tag, got & m, d & m);
    endtask

    // ---------------- driver ----------------
    // One full transaction; hold > 0 keeps resp_ready low for hold cycles while
    // a second (to be ignored) store to 0x3000 is offered.
    task automatic transact(input logic w, input logic [63:0] a, input logic [63:0] d,
                            input int hold, input string tag);
        logic [63:0] exp_d, exp_m, got_exp;
        logic        e;
        int          lat;
        e = exp_err(a);
        if (e || w) begin
            exp_d = '0;
            exp_m = '1;
        end else begin
            mdl_load(a, exp_d, exp_m);
        end
        exp_q.push_back(exp_d);

        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_write  = w;
        bus.req_addr   = a;
        bus.req_wdata  = d;
        bus.resp_ready = (hold == 0);
        #1 check({tag, ".req_ready"}, 64'(bus.req_ready), 64'd1);

        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        bus.req_write = 1'($urandom_range(0, 1));
        bus.req_addr  = {$urandom, $urandom};
        bus.req_wdata = {$urandom, $urandom};
        if (!e && w) mdl_store(a, d);

        lat = 0;
        while (bus.resp_valid !== 1'b1 && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, ".latency"}, 64'(lat), 64'(LATENCY));
        got_exp = exp_q.pop_front();
        check({tag, ".err"}, 64'(bus.resp_err), 64'(e));
        check({tag, ".rdata"}, bus.resp_rdata & exp_m, got_exp & exp_m);

        if (hold > 0) begin
            repeat (hold) begin
                @(negedge clk);
                bus.req_valid = 1'b1;
                bus.req_write = 1'b1;
                bus.req_addr  = 64'h3000;
                bus.req_wdata = 64'hBAD0_BAD0_BAD0_BAD0;
                @(posedge clk);
                #1;
                check({tag, ".bp_valid"}, 64'(bus.resp_valid), 64'd1);
                check({tag, ".bp_ready"}, 64'(bus.req_ready), 64'd0);
                check({tag, ".bp_rdata"}, bus.resp_rdata & exp_m, got_exp & exp_m);
                check({tag, ".bp_err"}, 64'(bus.resp_err), 64'(e));
            end
            @(negedge clk);
            bus.req_valid  = 1'b0;
            bus.resp_ready = 1'b1;
        end
        @(posedge clk);
        #1;
        check({tag, ".done_valid"}, 64'(bus.resp_valid), 64'd0);
        check({tag, ".done_ready"}, 64'(bus.req_ready), 64'd1);
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        logic [63:0] a, d;
        int          hold;

        bus.req_valid  = 1'b0;
        bus.req_write  = 1'b0;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;
        bus.resp_ready = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("rst.state", 64'(state_dbg), 64'(IDLE));
        check("rst.req_ready", 64'(bus.req_ready), 64'd1);
        check("rst.resp_valid", 64'(bus.resp_valid), 64'd0);
        check("rst.rdata", bus.resp_rdata, 64'd0);
        check("rst.err", 64'(bus.resp_err), 64'd0);

        // Store then load, plus byte order through the backdoor.
        transact(1'b1, 64'h100, 64'h1122334455667788, 0, "st100");
        transact(1'b0, 64'h100, 64'h0, 0, "ld100");
        check("bd.mem100", 64'(dut.u_mem.mem[19'h100]), 64'h88);
        check("bd.mem107", 64'(dut.u_mem.mem[19'h107]), 64'h11);

        // Misaligned load spanning 0x103..0x10A.
        transact(1'b1, 64'h108, {$urandom, $urandom}, 0, "st108");
        transact(1'b0, 64'h103, 64'h0, 0, "ld103");

        // Range boundary: 0x7FFF8 is the last legal address.
        transact(1'b1, 64'h7FFF8, 64'hCAFEF00D_5A5A0101, 0, "st7fff8");
        transact(1'b1, 64'h7FFF9, 64'hFFFF_FFFF_FFFF_FFFF, 0, "st7fff9");
        transact(1'b0, 64'h7FFF8, 64'h0, 0, "ld7fff8");
        check_backdoor("bd.7fff8", 64'h7FFF8);
        transact(1'b0, 64'hFFFF_FFFF_FFFF_FFF8, 64'h0, 0, "ld_huge");

        // Backpressure with an ignored second request.
        transact(1'b1, 64'h3000, 64'h0F1E2D3C4B5A6978, 0, "st3000");
        transact(1'b0, 64'h100, 64'h0, 5, "ld100_bp");
        check_backdoor("bd.3000", 64'h3000);

        // Reset while a store is in WAIT.
        transact(1'b1, 64'h200, 64'h0123456789ABCDEF, 0, "st200");
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        bus.req_addr  = 64'h200;
        bus.req_wdata = 64'hDEAD;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        check("rw.state", 64'(state_dbg), 64'(IDLE));
        check("rw.resp_valid", 64'(bus.resp_valid), 64'd0);
        check("rw.req_ready", 64'(bus.req_ready), 64'd1);
        repeat (3) @(posedge clk);
        #1;
        check("rw.resp_valid2", 64'(bus.resp_valid), 64'd0);
        check_backdoor("rw.mem200", 64'h200);

        // Reset while a response is held in RESP.
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_write  = 1'b0;
        bus.req_addr   = 64'h100;
        bus.resp_ready = 1'b0;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        repeat (LATENCY + 1) @(posedge clk);
        #1;
        check("rr.pre_valid", 64'(bus.resp_valid), 64'd1);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        bus.resp_ready = 1'b1;
        check("rr.resp_valid", 64'(bus.resp_valid), 64'd0);
        check("rr.req_ready", 64'(bus.req_ready), 64'd1);
        check("rr.rdata", bus.resp_rdata, 64'd0);

        // Randomized traffic against the model.
        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 3))
                0, 1:    a = 64'h1000 + 64'($urandom_range(0, 64));
                2:       a = 64'(MEM_BYTES) - 64'd16 + 64'($urandom_range(0, 24));
                default: a = 64'hFFFF_FFFF_FFFF_FFF0 + 64'($urandom_range(0, 15));
            endcase
            d    = {$urandom, $urandom};
            hold = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
            transact(1'($urandom_range(0, 1)), a, d, hold, "rnd");
        end
        check_backdoor("bd.3000_end", 64'h3000);
        check_backdoor("bd.100_end", 64'h100);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
